mfp_ahb_interconnect: RTL
=========================

// Module: mfp_ahb_interconnect
//
// PURPOSE
//  Parametrised AHB-lite interconnect for one master and N_SLV slaves. It supersedes the
//  fixed 7-slave decoder/mux pair with a proper data-phase pipeline, so slaves can insert
//  wait states through HREADYOUT and signal errors through HRESP.
//  - Unmapped accesses go to a built-in default slave that returns an AHB ERROR.
//  - Sits between the MIPSfpga core bus and the RAM/GPIO/VRAM/SRAM/SD slaves.
//
// PARAMETERS
//  N_SLV       7                      number of slaves (1..16)
//  SLV_BASE    {N_SLV{32'h0}}         flattened N_SLV*32 base addresses; slot i = [32*i+:32]
//  SLV_MASK    {N_SLV{32'hF0000000}}  flattened N_SLV*32 compare masks; hit_i = ((HADDR & MASK_i) == BASE_i)
//  TIMEOUT     255                    max wait cycles before forced ERROR (used only with MFP_AHB_IC_TIMEOUT_EN)
//
// PORTS
//  HCLK         in   1         bus clock; all state is on its rising edge
//  HRESET       in   1         asynchronous, active-high reset
//  HADDR        in   32        master address (address phase)
//  HTRANS       in   2         master transfer type
//  HRDATA       out  32        read data to master (data phase)
//  HREADY       out  1         transfer done to master; also broadcast to all slaves
//  HRESP        out  1         0 = OKAY, 1 = ERROR to master
//  HSEL         out  N_SLV     one-hot slave select (address phase, combinational)
//  HRDATA_S     in   32*N_SLV  slave read data, slot i = [32*i+:32]
//  HREADYOUT_S  in   N_SLV     per-slave ready
//  HRESP_S      in   N_SLV     per-slave response
//  DEC_ERR      out  1         1-cycle pulse on the first ERROR cycle of a default-slave access
//  TO_ERR       out  1         sticky timeout flag, cleared only by HRESET (tied 0 without the macro)
//
// BEHAVIOUR
//  - Decode: hit vector from HADDR. HSEL = lowest-index hit only. HSEL may be nonzero during IDLE;
//    slaves qualify with HTRANS. No hit while HTRANS is NONSEQ or SEQ selects the default slave.
//  - Data-phase select sel_d (N_SLV+1 bits incl. default) loads the address-phase select only
//    when HREADY=1. It holds while HREADY=0.
//  - Outputs follow sel_d: HRDATA, HREADY and HRESP come from the selected slave. When sel_d is
//    none, HRDATA=0, HREADY=1, HRESP=0. Zero added latency: the slave's data-phase cycle is the
//    master's.
//  - Default-slave FSM:
//    - DS_IDLE -> DS_ERR1 when an unmapped NONSEQ/SEQ is accepted (HREADY=1).
//    - DS_ERR1: HREADY=0, HRESP=1, DEC_ERR=1.
//    - DS_ERR2: HREADY=1, HRESP=1. Then back to DS_IDLE, or straight to DS_ERR1 if another
//      unmapped access is accepted in the same cycle.
//    - Unmapped IDLE/BUSY transfers stay in DS_IDLE and get OKAY with zero wait.
//  - A slave's 2-cycle ERROR is passed through unchanged. The master's HTRANS=IDLE during
//    ERROR is the master's responsibility; the interconnect does not cancel anything.
//  - Reset values: sel_d = none, FSM = DS_IDLE, HREADY=1, HRESP=0, HRDATA=0, DEC_ERR=0,
//    TO_ERR=0, timeout counter = 0.
//  - Reset mid-wait: all state clears immediately (async). Outputs return to idle values the
//    same cycle.
//  - Back-to-back transfers to different slaves: the next address phase is decoded while the
//    current data phase stalls. sel_d does not switch until HREADY=1.
//
// CONFIGURATION
//  - MFP_AHB_IC_TIMEOUT_EN defined:
//    - A counter increments each cycle sel_d is a real slave and that slave's HREADYOUT=0.
//      It clears when HREADY=1.
//    - When the count reaches TIMEOUT, the interconnect forces the 2-cycle ERROR
//      (HREADY=0/HRESP=1, then HREADY=1/HRESP=1), ignores that slave's outputs for both
//      cycles, sets TO_ERR, then loads sel_d normally.
//  - Not defined: no counter; a slave may stall forever; TO_ERR tied 0.
//
// STRUCTURE
//  - mfp_ahb_const.vh: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, and the per-slave
//    base/mask constants the top level passes as SLV_BASE/SLV_MASK.
//  - One sub-module, mfp_ahb_default_slave: the DS_* FSM, DEC_ERR and, under the macro, the
//    timeout counter/forced-error path. Decode, sel_d and the output mux stay in the top module.
//
// TESTING
//  1. Read slave 2 (HADDR=0xbf800004, NONSEQ), HREADYOUT_S[2]=1, HRDATA_S[2]=0x12345678
//     -> HSEL=7'b0000100; next cycle HRDATA=0x12345678, HREADY=1, HRESP=0.
//  2. Slave 1 holds HREADYOUT low 3 cycles, next NONSEQ targets slave 0
//     -> HREADY=0 x3; sel_d stays slave 1; slave 0 data phase follows only after HREADY=1.
//  3. NONSEQ to unmapped 0x40000000 -> cycle 1 HREADY=0/HRESP=1/DEC_ERR=1,
//     cycle 2 HREADY=1/HRESP=1; IDLE to the same address -> OKAY, zero wait.
//  4. Overlapping bases (slave 0 and slave 3 both hit) -> HSEL selects slave 0 only.
//  5. HRESET asserted while slave 4 is stalling -> same cycle HREADY=1, HRESP=0, HRDATA=0;
//     FSM in DS_IDLE.
//  6. With MFP_AHB_IC_TIMEOUT_EN, TIMEOUT=8, slave 3 never ready -> after 8 wait cycles
//     2-cycle ERROR, TO_ERR=1 until reset.

Source files
------------

// File: rtl/mfp_ahb_interconnect_pkg.sv
// Shared AHB-lite encodings, default-slave state type and the MIPSfpga slave address map
// for the mfp_ahb_interconnect slice.
package mfp_ahb_interconnect_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Slot 0 is the least significant word: RAM, boot, GPIO, RAM-alias, VRAM, SRAM, SD.
  localparam int MFP_N_SLV = 7;
  localparam logic [32*MFP_N_SLV-1:0] MFP_SLV_BASE = {
    32'hbf000000, 32'h30000000, 32'h20000000, 32'h00000000,
    32'hbf800000, 32'h10000000, 32'h00000000
  };
  localparam logic [32*MFP_N_SLV-1:0] MFP_SLV_MASK = {
    32'hffff0000, 32'hf0000000, 32'hf0000000, 32'hf0000000,
    32'hffff0000, 32'hf0000000, 32'hff000000
  };

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_t;

  function automatic logic htrans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/mfp_ahb_default_slave.sv
// Default slave: two-cycle AHB ERROR for unmapped accesses, DEC_ERR pulse, and (with
// MFP_AHB_IC_TIMEOUT_EN) the wait-state timeout that forces the same ERROR sequence.
module mfp_ahb_default_slave
  import mfp_ahb_interconnect_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic i_accept,
  input  logic i_unmapped,
`ifdef MFP_AHB_IC_TIMEOUT_EN
  input  logic i_slv_stall,
`endif
  output logic o_active,
  output logic o_hready,
  output logic o_hresp,
  output logic o_dec_err,
  output logic o_to_err
);

  ds_state_t r_state;
  logic      r_hready;
  logic      r_hresp;
  logic      r_dec_err;
  logic      w_timeout;

`ifdef MFP_AHB_IC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_to_cnt;
  logic          r_to_err;

  assign w_timeout = (r_state == DS_IDLE) && i_slv_stall && (r_to_cnt == CW'(TIMEOUT - 1));

  // Counts only real-slave wait states; frozen while the forced ERROR is being driven.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      if (i_accept)
        r_to_cnt <= '0;
      else if ((r_state == DS_IDLE) && i_slv_stall)
        r_to_cnt <= r_to_cnt + CW'(1);
      if (w_timeout)
        r_to_err <= 1'b1;
    end
  end

  assign o_to_err = r_to_err;
`else
  assign w_timeout = 1'b0;
  assign o_to_err  = 1'b0;
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= DS_IDLE;
      r_hready  <= 1'b1;
      r_hresp   <= HRESP_OKAY;
      r_dec_err <= 1'b0;
    end else begin
      case (r_state)
        DS_IDLE: begin
          if ((i_accept && i_unmapped) || w_timeout) begin
            r_state   <= DS_ERR1;
            r_hready  <= 1'b0;
            r_hresp   <= HRESP_ERROR;
            r_dec_err <= i_accept && i_unmapped;
          end
        end
        DS_ERR1: begin
          r_state   <= DS_ERR2;
          r_hready  <= 1'b1;
          r_hresp   <= HRESP_ERROR;
          r_dec_err <= 1'b0;
        end
        DS_ERR2: begin
          if (i_accept && i_unmapped) begin
            r_state   <= DS_ERR1;
            r_hready  <= 1'b0;
            r_hresp   <= HRESP_ERROR;
            r_dec_err <= 1'b1;
          end else begin
            r_state   <= DS_IDLE;
            r_hready  <= 1'b1;
            r_hresp   <= HRESP_OKAY;
            r_dec_err <= 1'b0;
          end
        end
        default: begin
          r_state   <= DS_IDLE;
          r_hready  <= 1'b1;
          r_hresp   <= HRESP_OKAY;
          r_dec_err <= 1'b0;
        end
      endcase
    end
  end

  assign o_active  = (r_state != DS_IDLE);
  assign o_hready  = r_hready;
  assign o_hresp   = r_hresp;
  assign o_dec_err = r_dec_err;

endmodule

// File: rtl/mfp_ahb_interconnect.sv
// One-master, N_SLV-slave AHB-lite interconnect: address decode, data-phase select and
// response mux. Define MFP_AHB_IC_TIMEOUT_EN to enable the stalled-slave timeout.
module mfp_ahb_interconnect
  import mfp_ahb_interconnect_pkg::*;
#(
  parameter int                    N_SLV    = 7,
  parameter logic [N_SLV*32-1:0]   SLV_BASE = {N_SLV{32'h0}},
  parameter logic [N_SLV*32-1:0]   SLV_MASK = {N_SLV{32'hF0000000}},
  parameter int                    TIMEOUT  = 255
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  output logic [31:0]          HRDATA,
  output logic                 HREADY,
  output logic                 HRESP,
  output logic [N_SLV-1:0]     HSEL,
  input  logic [32*N_SLV-1:0]  HRDATA_S,
  input  logic [N_SLV-1:0]     HREADYOUT_S,
  input  logic [N_SLV-1:0]     HRESP_S,
  output logic                 DEC_ERR,
  output logic                 TO_ERR
);

  logic [N_SLV-1:0] w_hit;
  logic [N_SLV-1:0] w_hsel;
  logic             w_unmapped;
  logic [N_SLV:0]   r_sel_d;
  logic [31:0]      w_slv_rdata;
  logic             w_slv_ready;
  logic             w_slv_resp;
  logic             w_ds_active;
  logic             w_ds_hready;
  logic             w_ds_hresp;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_SLV; i++)
      w_hit[i] = ((HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]);
  end

  // Isolate the lowest set bit so overlapping windows resolve to the lowest index.
  assign w_hsel     = w_hit & (~w_hit + N_SLV'(1));
  assign w_unmapped = htrans_active(HTRANS) && (w_hit == '0);
  assign HSEL       = w_hsel;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)
      r_sel_d <= '0;
    else if (HREADY)
      r_sel_d <= {w_unmapped, w_hsel};
  end

  always_comb begin
    w_slv_rdata = '0;
    w_slv_ready = 1'b1;
    w_slv_resp  = HRESP_OKAY;
    for (int i = 0; i < N_SLV; i++) begin
      if (r_sel_d[i]) begin
        w_slv_rdata = HRDATA_S[32*i +: 32];
        w_slv_ready = HREADYOUT_S[i];
        w_slv_resp  = HRESP_S[i];
      end
    end
  end

  // An active default slave also covers the forced timeout ERROR, masking the real slave.
  always_comb begin
    if (w_ds_active || r_sel_d[N_SLV]) begin
      HRDATA = '0;
      HREADY = w_ds_hready;
      HRESP  = w_ds_hresp;
    end else begin
      HRDATA = w_slv_rdata;
      HREADY = w_slv_ready;
      HRESP  = w_slv_resp;
    end
  end

`ifdef MFP_AHB_IC_TIMEOUT_EN
  logic w_slv_stall;
  assign w_slv_stall = (|r_sel_d[N_SLV-1:0]) && !w_slv_ready;
`endif

  mfp_ahb_default_slave #(
    .TIMEOUT (TIMEOUT)
  ) u_default_slave (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .i_accept    (HREADY),
    .i_unmapped  (w_unmapped),
`ifdef MFP_AHB_IC_TIMEOUT_EN
    .i_slv_stall (w_slv_stall),
`endif
    .o_active    (w_ds_active),
    .o_hready    (w_ds_hready),
    .o_hresp     (w_ds_hresp),
    .o_dec_err   (DEC_ERR),
    .o_to_err    (TO_ERR)
  );

endmodule
